// File: rtl/boot_pkg.sv
// Shared types and header field layout for the boot loader.
// Optional checksum stage is enabled with BOOT_LOADER_CKSUM_EN.
package boot_pkg;

   typedef enum logic [2:0] {
      ST_HDR,
      ST_LOAD,
      ST_DRAIN,
      ST_CKSUM,
      ST_RUN
   } state_e;

   typedef enum logic [1:0] {
      TGT_IMEM = 2'b00,
      TGT_DMEM = 2'b01,
      TGT_GO   = 2'b10,
      TGT_RSVD = 2'b11
   } tgt_e;

   localparam int TGT_MSB  = 31;
   localparam int TGT_LSB  = 30;
   localparam int CNT_MSB  = 29;
   localparam int CNT_LSB  = 16;
   localparam int ADDR_MSB = 15;
   localparam int ADDR_LSB = 0;
   localparam int CNT_W    = 14;
   localparam int ADDR_W   = 16;

endpackage

// File: rtl/boot_loader_if.sv
// Stream input and the two memory write ports of the boot loader.
interface boot_loader_if
   import boot_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int IMEM_DEPTH = 64,
   parameter int DMEM_DEPTH = 64
);
   localparam int IMEM_AW = $clog2(IMEM_DEPTH);
   localparam int DMEM_AW = $clog2(DMEM_DEPTH);

   logic               s_valid;
   logic               s_ready;
   logic [XLEN-1:0]    s_data;
   logic               imem_we;
   logic [IMEM_AW-1:0] imem_addr;
   logic [XLEN-1:0]    imem_wdata;
   logic               dmem_we;
   logic [DMEM_AW-1:0] dmem_addr;
   logic [XLEN-1:0]    dmem_wdata;

   modport master (
      input  s_valid, s_data,
      output s_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata
   );

   modport slave (
      output s_valid, s_data,
      input  s_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr, dmem_wdata
   );
endinterface

// File: rtl/boot_hdr_decode.sv
// Combinational header split plus reserved-target / range error detection.
module boot_hdr_decode
   import boot_pkg::*;
#(
   parameter int IMEM_DEPTH = 64,
   parameter int DMEM_DEPTH = 64
) (
   input  logic [31:0]       hdr_i,
   output tgt_e              tgt_o,
   output logic [CNT_W-1:0]  count_o,
   output logic [ADDR_W-1:0] start_o,
   output logic              err_o
);
   logic [ADDR_W:0] end_addr;

   assign tgt_o   = tgt_e'(hdr_i[TGT_MSB:TGT_LSB]);
   assign count_o = hdr_i[CNT_MSB:CNT_LSB];
   assign start_o = hdr_i[ADDR_MSB:ADDR_LSB];
   // One extra bit so start+count can never wrap past the depth compare.
   assign end_addr = {1'b0, start_o} + {{(ADDR_W + 1 - CNT_W){1'b0}}, count_o};

   always_comb begin
      err_o = 1'b0;
      case (tgt_o)
         TGT_IMEM: err_o = end_addr > (ADDR_W + 1)'(IMEM_DEPTH);
         TGT_DMEM: err_o = end_addr > (ADDR_W + 1)'(DMEM_DEPTH);
         TGT_RSVD: err_o = 1'b1;
         default:  err_o = 1'b0;
      endcase
   end
endmodule

// File: rtl/boot_loader.sv
// Packet-driven IMEM/DMEM loader that holds the core in reset until GO.
// Define BOOT_LOADER_CKSUM_EN to require an XOR checksum word after each payload.
module boot_loader
   import boot_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int IMEM_DEPTH = 64,
   parameter int DMEM_DEPTH = 64
) (
   input  logic          clk,
   input  logic          rst,
   boot_loader_if.master bus,
   output logic          core_rst,
   output logic          done,
   output logic          err
);
   localparam int IMEM_AW = $clog2(IMEM_DEPTH);
   localparam int DMEM_AW = $clog2(DMEM_DEPTH);

   state_e             state_q;
   tgt_e               tgt_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [CNT_W-1:0]   rem_q;
   logic               ready_q, core_rst_q, done_q, err_q;
   logic               imem_we_q, dmem_we_q;
   logic [IMEM_AW-1:0] imem_addr_q;
   logic [DMEM_AW-1:0] dmem_addr_q;
   logic [XLEN-1:0]    imem_wdata_q, dmem_wdata_q;
`ifdef BOOT_LOADER_CKSUM_EN
   logic [XLEN-1:0]    xor_q;
`endif

   tgt_e               hd_tgt;
   logic [CNT_W-1:0]   hd_count;
   logic [ADDR_W-1:0]  hd_start;
   logic               hd_err;
   logic               accept;
   logic               unused_addr;

   boot_hdr_decode #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) u_dec (
      .hdr_i  (bus.s_data[31:0]),
      .tgt_o  (hd_tgt),
      .count_o(hd_count),
      .start_o(hd_start),
      .err_o  (hd_err)
   );

   assign accept      = bus.s_valid && ready_q;
   assign unused_addr = ^addr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_HDR;
         tgt_q        <= TGT_IMEM;
         addr_q       <= '0;
         rem_q        <= '0;
         ready_q      <= 1'b0;
         core_rst_q   <= 1'b1;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         imem_we_q    <= 1'b0;
         dmem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         dmem_addr_q  <= '0;
         imem_wdata_q <= '0;
         dmem_wdata_q <= '0;
`ifdef BOOT_LOADER_CKSUM_EN
         xor_q        <= '0;
`endif
      end else begin
         imem_we_q <= 1'b0;
         dmem_we_q <= 1'b0;
         if (state_q != ST_RUN) ready_q <= 1'b1;
         if (accept) begin
            case (state_q)
               ST_HDR: begin
                  if (hd_tgt == TGT_GO) begin
                     if (!err_q) begin
                        state_q    <= ST_RUN;
                        ready_q    <= 1'b0;
                        core_rst_q <= 1'b0;
                        done_q     <= 1'b1;
                     end
                  end else if (hd_err) begin
                     err_q <= 1'b1;
                     rem_q <= hd_count;
                     if (hd_count != '0) state_q <= ST_DRAIN;
                  end else if (hd_count != '0) begin
                     state_q <= ST_LOAD;
                     tgt_q   <= hd_tgt;
                     addr_q  <= hd_start;
                     rem_q   <= hd_count;
`ifdef BOOT_LOADER_CKSUM_EN
                     xor_q   <= '0;
`endif
                  end
               end
               ST_LOAD: begin
                  if (tgt_q == TGT_DMEM) begin
                     dmem_we_q    <= 1'b1;
                     dmem_addr_q  <= addr_q[DMEM_AW-1:0];
                     dmem_wdata_q <= bus.s_data;
                  end else begin
                     imem_we_q    <= 1'b1;
                     imem_addr_q  <= addr_q[IMEM_AW-1:0];
                     imem_wdata_q <= bus.s_data;
                  end
                  addr_q <= addr_q + 16'd1;
                  rem_q  <= rem_q - 14'd1;
`ifdef BOOT_LOADER_CKSUM_EN
                  xor_q  <= xor_q ^ bus.s_data;
                  if (rem_q == 14'd1) state_q <= ST_CKSUM;
`else
                  if (rem_q == 14'd1) state_q <= ST_HDR;
`endif
               end
`ifdef BOOT_LOADER_CKSUM_EN
               ST_CKSUM: begin
                  if (bus.s_data != xor_q) err_q <= 1'b1;
                  state_q <= ST_HDR;
               end
`endif
               ST_DRAIN: begin
                  rem_q <= rem_q - 14'd1;
                  if (rem_q == 14'd1) state_q <= ST_HDR;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.s_ready    = ready_q;
   assign bus.imem_we    = imem_we_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_wdata = imem_wdata_q;
   assign bus.dmem_we    = dmem_we_q;
   assign bus.dmem_addr  = dmem_addr_q;
   assign bus.dmem_wdata = dmem_wdata_q;
   assign core_rst       = core_rst_q;
   assign done           = done_q;
   assign err            = err_q;
endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: stimulus pushes expected writes, a monitor pops them.
module tb_boot_loader;
   import boot_pkg::*;

   localparam int XLEN = 32;
   localparam int IMEM_DEPTH = 64;
   localparam int DMEM_DEPTH = 64;

   typedef struct packed {
      logic        is_d;
      logic [5:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic core_rst, done, err;
   int   vectors = 0;
   int   miscompares = 0;
   wr_t  exp_q[$];

   boot_loader_if #(.XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) bus ();

   boot_loader #(.XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .core_rst(core_rst),
      .done    (done),
      .err     (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end else begin
         $display("ok   %s = %h", name, act);
      end
   endtask

   // Monitor: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (rst && (bus.imem_we || bus.dmem_we)) begin
         wr_t act;
         act.is_d = bus.dmem_we;
         act.addr = bus.dmem_we ? bus.dmem_addr : bus.imem_addr;
         act.data = bus.dmem_we ? bus.dmem_wdata : bus.imem_wdata;
         vectors++;
         if (bus.imem_we && bus.dmem_we) begin
            miscompares++;
            $display("FAIL dual_strobe actual=both required=one");
         end else if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write actual=%h required=none", act);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (act !== e) begin
               miscompares++;
               $display("FAIL write actual=%h required=%h", act, e);
            end else begin
               $display("ok   write %s[%0d] = %h", act.is_d ? "dmem" : "imem", act.addr, act.data);
            end
         end
      end
   end

   task automatic send(input logic [31:0] w);
      int n = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = w;
      while (!bus.s_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout actual=not_ready required=ready word=%h", w);
      end else begin
         @(posedge clk); #1;
      end
      bus.s_valid = 1'b0;
   endtask

   task automatic expect_wr(input logic d, input logic [5:0] a, input logic [31:0] w);
      exp_q.push_back('{is_d: d, addr: a, data: w});
   endtask

   // Sends header + payload (+ checksum when enabled); optionally idle between words.
   task automatic send_pkt(input logic [31:0] hdr, input logic [31:0] w[8], input int n,
                           input logic gap);
      logic [31:0] x = '0;
      send(hdr);
      for (int i = 0; i < n; i++) begin
         expect_wr(hdr[30], 6'(hdr[5:0] + 6'(i)), w[i]);
         x = x ^ w[i];
         send(w[i]);
         if (gap) begin @(posedge clk); #1; end
      end
`ifdef BOOT_LOADER_CKSUM_EN
      if (n != 0) send(x);
`endif
   endtask

   task automatic do_reset();
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_s_ready", {31'b0, bus.s_ready}, 32'd0);
      chk("rst_we", {30'b0, bus.imem_we, bus.dmem_we}, 32'd0);
      chk("rst_addr", {20'b0, bus.imem_addr, bus.dmem_addr}, 32'd0);
      chk("rst_wdata", bus.imem_wdata | bus.dmem_wdata, 32'd0);
      chk("rst_core_done_err", {29'b0, core_rst, done, err}, 32'b100);
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] w[8];
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      repeat (2) @(posedge clk);
      do_reset();

      w = '{32'h02400313, 32'h00602223, 32'h00402383, 32'h00730463,
            32'h00001297, 32'h00001217, 32'h0, 32'h0};
      send_pkt(32'h00060000, w, 6, 1'b0);
      settle();
      chk("imem_load_err", {31'b0, err}, 32'd0);
      chk("imem_load_drained", exp_q.size(), 32'd0);

      send_pkt(32'h00000003, w, 0, 1'b0);
      settle();
      chk("count0_err", {31'b0, err}, 32'd0);

      w = '{32'hAAAA0001, 32'hBBBB0002, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      send_pkt(32'h0002003E, w, 2, 1'b0);
      settle();
      chk("top_of_depth_err", {31'b0, err}, 32'd0);

      w = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      send_pkt(32'h40030010, w, 3, 1'b1);
      settle();
      chk("bp_drained", exp_q.size(), 32'd0);

      send(32'h00060000);
      expect_wr(1'b0, 6'd0, 32'hC0DE0000);
      send(32'hC0DE0000);
      expect_wr(1'b0, 6'd1, 32'hC0DE0001);
      send(32'hC0DE0001);
      @(posedge clk);
      do_reset();
      w = '{32'h5555AAAA, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      send_pkt(32'h00010005, w, 1, 1'b0);
      settle();
      chk("after_reset_err", {31'b0, err}, 32'd0);

      w = '{32'd5, 32'd10, 32'd20, 32'd30, 32'd40, 32'h0, 32'h0, 32'h0};
      send_pkt(32'h40050000, w, 5, 1'b0);
      settle();
      chk("pre_go_core_rst", {31'b0, core_rst}, 32'd1);
      send(32'h80000000);
      chk("go_core_rst", {31'b0, core_rst}, 32'd0);
      chk("go_done", {31'b0, done}, 32'd1);
      chk("run_s_ready", {31'b0, bus.s_ready}, 32'd0);

      do_reset();
      send(32'h0004003E);
      chk("range_err_rise", {31'b0, err}, 32'd1);
      for (int i = 0; i < 4; i++) send(32'hDEAD0000 + i);
      send(32'h80000000);
      settle();
      chk("range_go_ignored", {30'b0, core_rst, done}, 32'b10);
      chk("range_still_ready", {31'b0, bus.s_ready}, 32'd1);

`ifdef BOOT_LOADER_CKSUM_EN
      do_reset();
      w = '{32'h0F, 32'hF0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      send(32'h00020000);
      expect_wr(1'b0, 6'd0, 32'h0F);
      send(32'h0F);
      expect_wr(1'b0, 6'd1, 32'hF0);
      send(32'hF0);
      send(32'hFF);
      chk("cksum_good_err", {31'b0, err}, 32'd0);
      send(32'h00020000);
      expect_wr(1'b0, 6'd0, 32'h0F);
      send(32'h0F);
      expect_wr(1'b0, 6'd1, 32'hF0);
      send(32'hF0);
      send(32'h00);
      chk("cksum_bad_err", {31'b0, err}, 32'd1);
`endif

      settle();
      chk("final_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/boot_loader.md
# boot_loader

Synthesizable boot loader between an external word stream (debug UART bridge, JTAG, test host) and the single-cycle datapath. It holds the core in reset and fills instruction and data memory from framed packets through their write ports, instead of hierarchical preloading. On a GO command it releases the core. Depths and word width are parameters, and two memory channels are supported.

## Interface
- `XLEN`, 32: word width, ≥32.
- `IMEM_DEPTH`, 64: instruction memory words, power of two, ≤65536.
- `DMEM_DEPTH`, 64: data memory words, power of two, ≤65536.
- `clk`  in  1  system clock.
- `rst`  in  1  one clock; reset is asynchronous and active-low.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  loader accepts word.
- `s_data`  in  XLEN  stream word.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_addr`  out  $clog2(IMEM_DEPTH)  word address.
- `imem_wdata`  out  XLEN  write data.
- `dmem_we`  out  1  data memory write strobe.
- `dmem_addr`  out  $clog2(DMEM_DEPTH)  word address.
- `dmem_wdata`  out  XLEN  write data.
- `core_rst`  out  1  active-high reset to datapath.
- `done`  out  1  core released.
- `err`  out  1  sticky protocol error.

## Operation
- A word is accepted when `s_valid && s_ready`. `s_valid`/`s_data` must hold until accepted.
- Header word fields:
  - [31:30] target: 00 IMEM, 01 DMEM, 10 GO, 11 reserved.
  - [29:16] count (payload words).
  - [15:0] start word address.
  - Bits above 31 are ignored when XLEN > 32.
- States and transitions:
  - HDR → LOAD: IMEM/DMEM header, count ≠ 0, range valid.
  - HDR → HDR: count 0. No writes.
  - HDR → RUN: GO header with `err`=0.
  - HDR → DRAIN: reserved target, or start+count > target depth. This sets `err`.
  - LOAD: each accepted word is written to the target at the current address, then the address increments. Exit after count words.
  - DRAIN: consumes count words with no writes, then returns to HDR. Count 0 returns immediately.
  - RUN: terminal until reset.
- The range check is computed 17 bits wide, so no wrap-around occurs. Writing exactly up to depth−1 is legal.
- GO while `err`=1 is ignored. The loader stays in HDR and `core_rst` stays 1.
- `s_ready`=1 in HDR/LOAD/DRAIN(/CKSUM); 0 in RUN and while in reset.
- Reset mid-load aborts the load. Memory contents already written are kept; the loader restarts in HDR.

## Timing
- Reset values: `s_ready`=0, `imem_we`=`dmem_we`=0, all addresses/wdata 0, `core_rst`=1, `done`=0, `err`=0.
- Write outputs are registered:
  - Strobe, address and data appear the cycle after acceptance.
  - The strobe is one cycle wide per word.
  - Back-to-back acceptance gives back-to-back strobes.
- GO accepted in cycle N: `core_rst`=0 and `done`=1 from cycle N+1.
- `err` rises the cycle after the offending header (or checksum word) is accepted.
- The header itself produces no write. The first payload strobe is ≥2 cycles after the header.

## Configuration
- `BOOT_LOADER_CKSUM_EN` defined:
  - After each IMEM/DMEM payload, a CKSUM state accepts one extra word.
  - It must equal the XOR of all payload words of that packet.
  - Mismatch sets `err`; writes already done are kept.
  - Count-0 packets have no checksum word.
- Undefined: no CKSUM state; packets are header plus payload only.

## Structure
- `boot_pkg`:
  - state enum (HDR, LOAD, DRAIN, CKSUM, RUN)
  - target codes
  - header field bit positions
  - the 14-bit count and 16-bit address field widths
- Sub-module `boot_hdr_decode`: combinational. Splits the header into target/count/start and flags range or reserved errors for the given depths.
- The FSM, address counter, remaining-word counter and checksum accumulator live in `boot_loader`.

## Test plan
- IMEM load:
  - Stimulus: header 0x00060000, then 0x02400313, 0x00602223, 0x00402383, 0x00730463, 0x00001297, 0x00001217.
  - Response: six `imem_we` pulses at addr 0–5 with those data; `err`=0.
- DMEM plus GO:
  - Stimulus: header 0x40050000, then words 5, 10, 20, 30, 40; then 0x80000000.
  - Response: `dmem_we` at addr 0–4; `core_rst` falls and `done` rises the cycle after GO.
- Range error (depth 64):
  - Stimulus: header 0x0004003E, four words, then GO.
  - Response: `err`=1, no `imem_we`, GO ignored, `core_rst` stays 1.
- Backpressure:
  - Stimulus: `s_valid` toggled every other cycle during a 3-word DMEM load at start 0x10.
  - Response: exactly three strobes at addr 0x10–0x12, no duplicates.
- Reset mid-load:
  - Stimulus: `rst` low after 2 of 6 IMEM words.
  - Response: all outputs at reset values, addr 0/1 contents kept. A fresh header 0x00010005 plus one word writes addr 5.
- Checksum, with `BOOT_LOADER_CKSUM_EN` defined:
  - Stimulus: header 0x00020000, words 0x0F and 0xF0, checksum 0xFF.
  - Response: `err`=0.
  - With checksum 0x00 instead: `err`=1.
